// File: rtl/riscv_lsu_pkg.sv
// Shared types and constants for the RV32I load/store unit.
// Holds the funct3 encodings, the LSU state enum and the memory geometry.
package riscv_lsu_pkg;

    localparam int REG_WIDTH   = 32;
    localparam int MEM_SIZE    = 65536;
    localparam int MEM_WIDTH   = 4;
    localparam int LSU_TIMEOUT = 255;

    typedef enum logic [2:0] {
        LD_LB  = 3'd0,
        LD_LH  = 3'd1,
        LD_LW  = 3'd2,
        LD_LBU = 3'd4,
        LD_LHU = 3'd5
    } lsu_ld_funct3_e;

    typedef enum logic [2:0] {
        ST_SB = 3'd0,
        ST_SH = 3'd1,
        ST_SW = 3'd2
    } lsu_st_funct3_e;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_CHECK,
        LSU_REQ,
        LSU_DONE
    } lsu_state_t;

    // Loads 3/6/7 and stores 3..7 have no RV32I meaning.
    function automatic logic lsu_funct3_illegal(input logic we, input logic [2:0] funct3);
        if (we) begin
            return funct3 > 3'd2;
        end
        return (funct3 == 3'd3) || (funct3[2:1] == 2'b11);
    endfunction

endpackage

// File: rtl/riscv_lsu_if.sv
// Core-side request/response bundle and memory-side bus bundle of the LSU.
// The master modport is the side that initiates transfers on that bundle.
interface riscv_lsu_if
    import riscv_lsu_pkg::*;
#(
    parameter int XLEN = REG_WIDTH
) ();
    logic            lsu_valid_i;
    logic            lsu_ready_o;
    logic            lsu_we_i;
    logic [2:0]      lsu_funct3_i;
    logic [XLEN-1:0] lsu_addr_i;
    logic [XLEN-1:0] lsu_wdata_i;
    logic            lsu_done_o;
    logic [XLEN-1:0] lsu_rdata_o;
    logic            lsu_misalign_o;
    logic            lsu_fault_o;

    modport master (
        output lsu_valid_i, lsu_we_i, lsu_funct3_i, lsu_addr_i, lsu_wdata_i,
        input  lsu_ready_o, lsu_done_o, lsu_rdata_o, lsu_misalign_o, lsu_fault_o
    );
    modport slave (
        input  lsu_valid_i, lsu_we_i, lsu_funct3_i, lsu_addr_i, lsu_wdata_i,
        output lsu_ready_o, lsu_done_o, lsu_rdata_o, lsu_misalign_o, lsu_fault_o
    );
endinterface

interface riscv_lsu_mem_if
    import riscv_lsu_pkg::*;
#(
    parameter int XLEN = REG_WIDTH,
    parameter int AW   = $clog2(MEM_SIZE) - 2,
    parameter int BE_W = MEM_WIDTH
) ();
    logic            mem_req_o;
    logic            mem_we_o;
    logic [BE_W-1:0] mem_be_o;
    logic [AW-1:0]   mem_addr_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic            mem_ack_i;
    logic [XLEN-1:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i
    );
    modport slave (
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i
    );
endinterface

// File: rtl/riscv_lsu_align.sv
// Combinational lane logic: byte enables, replicated write lanes and
// sign/zero extension of the selected read byte or half.
module riscv_lsu_align
    import riscv_lsu_pkg::*;
#(
    parameter int XLEN = REG_WIDTH,
    parameter int BE_W = MEM_WIDTH
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [BE_W-1:0] be,
    output logic [XLEN-1:0] wdata_lane,
    output logic [XLEN-1:0] rdata_ext
);
    logic [1:0]  size;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign size = funct3[1:0];

    always_comb begin
        case (size)
            2'b00:   be = BE_W'(1) << addr_lo;
            2'b01:   be = BE_W'(3) << addr_lo;
            default: be = '1;
        endcase
    end

    // Each lane picks the byte it carries for the access width.
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
        assign wdata_lane[gi*8 +: 8] = (size == 2'b00) ? wdata[7:0] :
                                       (size == 2'b01) ? wdata[(gi % 2)*8 +: 8] :
                                                         wdata[gi*8 +: 8];
    end

    assign byte_sel = mem_rdata[{addr_lo, 3'b000} +: 8];
    assign half_sel = mem_rdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        case (funct3)
            LD_LB:   rdata_ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LD_LH:   rdata_ext = {{(XLEN-16){half_sel[15]}}, half_sel};
            LD_LBU:  rdata_ext = {{(XLEN-8){1'b0}}, byte_sel};
            LD_LHU:  rdata_ext = {{(XLEN-16){1'b0}}, half_sel};
            default: rdata_ext = mem_rdata;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// RV32I load/store unit: accepts one request, validates it, runs a single
// word-memory transaction with timeout, and returns extended data plus flags.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int XLEN      = REG_WIDTH,
    parameter int MEM_BYTES = MEM_SIZE,
    parameter int BE_W      = MEM_WIDTH,
    parameter int TIMEOUT   = LSU_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst_n,
    riscv_lsu_if.slave      core,
    riscv_lsu_mem_if.master mem
);
    localparam int AW = $clog2(MEM_BYTES) - 2;
    localparam int CW = $clog2(TIMEOUT + 1);

    lsu_state_t      state_q, state_d;
    logic            we_q, we_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            misalign_q, misalign_d;
    logic            fault_q, fault_d;
    logic            mreq_q, mreq_d;
    logic            mwe_q, mwe_d;
    logic [BE_W-1:0] mbe_q, mbe_d;
    logic [AW-1:0]   maddr_q, maddr_d;
    logic [XLEN-1:0] mwdata_q, mwdata_d;

    logic [BE_W-1:0] be_c;
    logic [XLEN-1:0] wlane_c;
    logic [XLEN-1:0] rext_c;
    logic            illegal_c;
    logic            misalign_c;
    logic            oor_c;

    riscv_lsu_align #(
        .XLEN (XLEN),
        .BE_W (BE_W)
    ) u_align (
        .funct3     (funct3_q),
        .addr_lo    (addr_q[1:0]),
        .wdata      (wdata_q),
        .mem_rdata  (mem.mem_rdata_i),
        .be         (be_c),
        .wdata_lane (wlane_c),
        .rdata_ext  (rext_c)
    );

    // Illegal codes never count as misaligned, so they always report a fault.
    assign illegal_c  = lsu_funct3_illegal(we_q, funct3_q);
    assign misalign_c = !illegal_c &&
                        (((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                         ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00)));
    assign oor_c      = addr_q >= XLEN'(MEM_BYTES);

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        ready_d    = ready_q;
        done_d     = 1'b0;
        rdata_d    = '0;
        misalign_d = 1'b0;
        fault_d    = 1'b0;
        mreq_d     = mreq_q;
        mwe_d      = mwe_q;
        mbe_d      = mbe_q;
        maddr_d    = maddr_q;
        mwdata_d   = mwdata_q;

        case (state_q)
            LSU_IDLE: begin
                if (core.lsu_valid_i && ready_q) begin
                    we_d     = core.lsu_we_i;
                    funct3_d = core.lsu_funct3_i;
                    addr_d   = core.lsu_addr_i;
                    wdata_d  = core.lsu_wdata_i;
                    cnt_d    = '0;
                    ready_d  = 1'b0;
                    state_d  = LSU_CHECK;
                end
            end
            LSU_CHECK: begin
                if (misalign_c) begin
                    misalign_d = 1'b1;
                    done_d     = 1'b1;
                    state_d    = LSU_DONE;
                end else if (illegal_c || oor_c) begin
                    fault_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = LSU_DONE;
                end else begin
                    mreq_d   = 1'b1;
                    mwe_d    = we_q;
                    mbe_d    = be_c;
                    maddr_d  = addr_q[AW+1:2];
                    mwdata_d = wlane_c;
                    state_d  = LSU_REQ;
                end
            end
            LSU_REQ: begin
                if (mem.mem_ack_i) begin
                    rdata_d = we_q ? '0 : rext_c;
                    done_d  = 1'b1;
                    state_d = LSU_DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    fault_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = LSU_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (state_d == LSU_DONE) begin
                    mreq_d   = 1'b0;
                    mwe_d    = 1'b0;
                    mbe_d    = '0;
                    maddr_d  = '0;
                    mwdata_d = '0;
                end
            end
            LSU_DONE: begin
                ready_d = 1'b1;
                state_d = LSU_IDLE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = LSU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LSU_IDLE;
            we_q       <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            fault_q    <= 1'b0;
            mreq_q     <= 1'b0;
            mwe_q      <= 1'b0;
            mbe_q      <= '0;
            maddr_q    <= '0;
            mwdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            fault_q    <= fault_d;
            mreq_q     <= mreq_d;
            mwe_q      <= mwe_d;
            mbe_q      <= mbe_d;
            maddr_q    <= maddr_d;
            mwdata_q   <= mwdata_d;
        end
    end

    assign core.lsu_ready_o    = ready_q;
    assign core.lsu_done_o     = done_q;
    assign core.lsu_rdata_o    = rdata_q;
    assign core.lsu_misalign_o = misalign_q;
    assign core.lsu_fault_o    = fault_q;
    assign mem.mem_req_o       = mreq_q;
    assign mem.mem_we_o        = mwe_q;
    assign mem.mem_be_o        = mbe_q;
    assign mem.mem_addr_o      = maddr_q;
    assign mem.mem_wdata_o     = mwdata_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed, table-driven bench for riscv_lsu with hand sequences for
// timeout, async reset mid-request and a late ack after reset.
module tb_riscv_lsu;
    import riscv_lsu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    riscv_lsu_if     core_if ();
    riscv_lsu_mem_if mem_if ();

    riscv_lsu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .core  (core_if.slave),
        .mem   (mem_if.master)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        int          ack_after;   // req cycle on which ack is given, 0 = never
        int          exp_lat;
        int          exp_req;
        logic [3:0]  be;
        logic [13:0] maddr;
        logic [31:0] mwdata;
        logic [31:0] rdata;
        logic        mis;
        logic        flt;
    } vec_t;

    vec_t vecs[$];
    int   vectors_applied = 0;
    int   miscompares = 0;
    int   cur = 0;

    function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                                logic [31:0] mrdata, int ack_after, int lat, int reqc,
                                logic [3:0] be, logic [13:0] maddr, logic [31:0] mwdata,
                                logic [31:0] rdata, logic mis, logic flt);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.mrdata = mrdata;
        v.ack_after = ack_after; v.exp_lat = lat; v.exp_req = reqc;
        v.be = be; v.maddr = maddr; v.mwdata = mwdata; v.rdata = rdata;
        v.mis = mis; v.flt = flt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL vec %0d %s: got %h expected %h", cur, nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int  t;
        int  reqc;
        bit  seen_done;
        @(negedge clk);
        t = 0;
        while (!core_if.lsu_ready_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("ready_before_accept", 32'(core_if.lsu_ready_o), 32'd1);
        core_if.lsu_valid_i  = 1'b1;
        core_if.lsu_we_i     = v.we;
        core_if.lsu_funct3_i = v.f3;
        core_if.lsu_addr_i   = v.addr;
        core_if.lsu_wdata_i  = v.wdata;
        mem_if.mem_rdata_i   = v.mrdata;
        @(posedge clk);
        @(negedge clk);
        core_if.lsu_valid_i = 1'b0;
        chk("ready_busy", 32'(core_if.lsu_ready_o), 32'd0);
        t = 1;
        reqc = 0;
        seen_done = 0;
        while (t <= 400) begin
            if (core_if.lsu_done_o) begin
                seen_done = 1;
                break;
            end
            if (mem_if.mem_req_o) begin
                reqc++;
                chk("mem_we", 32'(mem_if.mem_we_o), 32'(v.we));
                chk("mem_be", 32'(mem_if.mem_be_o), 32'(v.be));
                chk("mem_addr", 32'(mem_if.mem_addr_o), 32'(v.maddr));
                chk("mem_wdata", mem_if.mem_wdata_o, v.mwdata);
                mem_if.mem_ack_i = (v.ack_after != 0) && (reqc == v.ack_after);
            end else begin
                mem_if.mem_ack_i = 1'b0;
            end
            @(negedge clk);
            t++;
        end
        mem_if.mem_ack_i = 1'b0;
        chk("done_seen", 32'(seen_done), 32'd1);
        chk("latency", 32'(t), 32'(v.exp_lat));
        chk("req_cycles", 32'(reqc), 32'(v.exp_req));
        chk("rdata", core_if.lsu_rdata_o, v.rdata);
        chk("misalign", 32'(core_if.lsu_misalign_o), 32'(v.mis));
        chk("fault", 32'(core_if.lsu_fault_o), 32'(v.flt));
        chk("req_at_done", 32'(mem_if.mem_req_o), 32'd0);
        @(negedge clk);
        chk("done_one_cycle", 32'(core_if.lsu_done_o), 32'd0);
        vectors_applied++;
    endtask

    initial begin
        int t;
        core_if.lsu_valid_i  = 1'b0;
        core_if.lsu_we_i     = 1'b0;
        core_if.lsu_funct3_i = 3'd0;
        core_if.lsu_addr_i   = '0;
        core_if.lsu_wdata_i  = '0;
        mem_if.mem_ack_i     = 1'b0;
        mem_if.mem_rdata_i   = '0;

        //              we f3   addr          wdata         mrdata        ack lat req be    maddr     mwdata        rdata         mis flt
        vecs.push_back(mk(1, 3'd2, 32'h0000_0100, 32'hDEADBEEF, 32'h0,        2, 4,   2, 4'hF, 14'h040,  32'hDEADBEEF, 32'h0,        0, 0));
        vecs.push_back(mk(1, 3'd0, 32'h0000_0103, 32'h0000_00A5, 32'h0,       1, 3,   1, 4'h8, 14'h040,  32'hA5A5A5A5, 32'h0,        0, 0));
        vecs.push_back(mk(0, 3'd0, 32'h0000_0202, 32'h0,        32'h12F03456, 1, 3,   1, 4'h4, 14'h080,  32'h0,        32'hFFFFFFF0, 0, 0));
        vecs.push_back(mk(0, 3'd4, 32'h0000_0202, 32'h0,        32'h12F03456, 1, 3,   1, 4'h4, 14'h080,  32'h0,        32'h000000F0, 0, 0));
        vecs.push_back(mk(0, 3'd5, 32'h0000_0202, 32'h0,        32'h12F03456, 1, 3,   1, 4'hC, 14'h080,  32'h0,        32'h000012F0, 0, 0));
        vecs.push_back(mk(0, 3'd1, 32'h0000_0202, 32'h0,        32'h80010000, 3, 5,   3, 4'hC, 14'h080,  32'h0,        32'hFFFF8001, 0, 0));
        vecs.push_back(mk(0, 3'd1, 32'h0000_0200, 32'h0,        32'h1234ABCD, 1, 3,   1, 4'h3, 14'h080,  32'h0,        32'hFFFFABCD, 0, 0));
        vecs.push_back(mk(0, 3'd2, 32'h0000_0104, 32'h0,        32'hCAFEF00D, 1, 3,   1, 4'hF, 14'h041,  32'h0,        32'hCAFEF00D, 0, 0));
        vecs.push_back(mk(1, 3'd1, 32'h0000_0102, 32'h1234BEEF, 32'h0,        1, 3,   1, 4'hC, 14'h040,  32'hBEEFBEEF, 32'h0,        0, 0));
        vecs.push_back(mk(0, 3'd0, 32'h0000_FFFF, 32'h0,        32'h7F000000, 1, 3,   1, 4'h8, 14'h3FFF, 32'h0,        32'h0000007F, 0, 0));
        vecs.push_back(mk(1, 3'd0, 32'h0000_0001, 32'hFFFFFF3C, 32'h0,        1, 3,   1, 4'h2, 14'h000,  32'h3C3C3C3C, 32'h0,        0, 0));
        vecs.push_back(mk(0, 3'd2, 32'h0000_0102, 32'h0,        32'h0,        1, 2,   0, 4'h0, 14'h0,    32'h0,        32'h0,        1, 0));
        vecs.push_back(mk(0, 3'd1, 32'h0000_0001, 32'h0,        32'h0,        1, 2,   0, 4'h0, 14'h0,    32'h0,        32'h0,        1, 0));
        vecs.push_back(mk(1, 3'd2, 32'h0000_0203, 32'h11223344, 32'h0,        1, 2,   0, 4'h0, 14'h0,    32'h0,        32'h0,        1, 0));
        vecs.push_back(mk(0, 3'd2, 32'h0001_0000, 32'h0,        32'h0,        1, 2,   0, 4'h0, 14'h0,    32'h0,        32'h0,        0, 1));
        vecs.push_back(mk(0, 3'd2, 32'h0001_0002, 32'h0,        32'h0,        1, 2,   0, 4'h0, 14'h0,    32'h0,        32'h0,        1, 0));
        vecs.push_back(mk(0, 3'd3, 32'h0000_0000, 32'h0,        32'h0,        1, 2,   0, 4'h0, 14'h0,    32'h0,        32'h0,        0, 1));
        vecs.push_back(mk(0, 3'd6, 32'h0000_0002, 32'h0,        32'h0,        1, 2,   0, 4'h0, 14'h0,    32'h0,        32'h0,        0, 1));
        vecs.push_back(mk(1, 3'd4, 32'h0000_0000, 32'h0,        32'h0,        1, 2,   0, 4'h0, 14'h0,    32'h0,        32'h0,        0, 1));
        vecs.push_back(mk(0, 3'd4, 32'hFFFF_FFFF, 32'h0,        32'h0,        1, 2,   0, 4'h0, 14'h0,    32'h0,        32'h0,        0, 1));
        vecs.push_back(mk(0, 3'd2, 32'h0000_0004, 32'h0,        32'h55555555, 0, 257, 255, 4'hF, 14'h001, 32'h0,       32'h0,        0, 1));
        vecs.push_back(mk(0, 3'd2, 32'h0000_0008, 32'h0,        32'h01020304, 1, 3,   1, 4'hF, 14'h002,  32'h0,        32'h01020304, 0, 0));

        // Reset state while rst_n is held low.
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(core_if.lsu_ready_o), 32'd1);
        chk("rst_done", 32'(core_if.lsu_done_o), 32'd0);
        chk("rst_rdata", core_if.lsu_rdata_o, 32'd0);
        chk("rst_flags", {30'd0, core_if.lsu_misalign_o, core_if.lsu_fault_o}, 32'd0);
        chk("rst_req", 32'(mem_if.mem_req_o), 32'd0);
        chk("rst_be", 32'(mem_if.mem_be_o), 32'd0);
        chk("rst_wdata", mem_if.mem_wdata_o, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            cur = i;
            run_vec(vecs[i]);
            $display("vec %0d: we=%0d f3=%0d addr=%h rdata=%h mis=%0d flt=%0d",
                     i, vecs[i].we, vecs[i].f3, vecs[i].addr, core_if.lsu_rdata_o,
                     vecs[i].mis, vecs[i].flt);
        end

        // Reset asserted mid-request, then a stray ack after reset release.
        cur = 100;
        @(negedge clk);
        core_if.lsu_valid_i  = 1'b1;
        core_if.lsu_we_i     = 1'b0;
        core_if.lsu_funct3_i = 3'd2;
        core_if.lsu_addr_i   = 32'h0000_0010;
        @(posedge clk);
        @(negedge clk);
        core_if.lsu_valid_i = 1'b0;
        t = 0;
        while (!mem_if.mem_req_o && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("rst_seq_req_seen", 32'(mem_if.mem_req_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_req_drop", 32'(mem_if.mem_req_o), 32'd0);
        chk("async_ready", 32'(core_if.lsu_ready_o), 32'd1);
        chk("async_be", 32'(mem_if.mem_be_o), 32'd0);
        chk("async_done", 32'(core_if.lsu_done_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_if.mem_ack_i = 1'b1;
        @(negedge clk);
        mem_if.mem_ack_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("post_rst_done", 32'(core_if.lsu_done_o), 32'd0);
            chk("post_rst_req", 32'(mem_if.mem_req_o), 32'd0);
            chk("post_rst_ready", 32'(core_if.lsu_ready_o), 32'd1);
            @(negedge clk);
        end
        $display("reset-in-REQ sequence: ready=%0d req=%0d", core_if.lsu_ready_o, mem_if.mem_req_o);
        vectors_applied++;

        cur = 101;
        run_vec(vecs[7]);
        $display("post-reset vec: rdata=%h", core_if.lsu_rdata_o);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
